// File: rtl/accum_feeder.sv
// accum_feeder: moves per-tree results from the DTP lanes into the accumulator
// input FIFOs, counts them per lane, and once every lane has delivered its
// quota waits a fixed drain time, pulses the accumulator finish and captures
// the job result (argmax label for classification, value for regression).
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   i_start               job start pulse (IDLE only)
//   i_is_clf              job type, latched at start
//   i_n_results           results expected per lane, latched at start
//   i_abort               abort/flush request, any state
//   i_dtp_vld/i_dtp_data  per-lane result valid / data
//   o_dtp_rdy             per-lane ready (combinational)
//   o_in_fifo_push/_rear  accumulator FIFO push / write data (combinational)
//   i_in_fifo_is_full     accumulator FIFO full flags
//   o_is_clf              latched job type
//   o_is_accum_fin        one-cycle finish pulse to the accumulator
//   o_flush               one-cycle flush pulse after an abort
//   i_clf_accum_reg(_vld) classification registers and update pulses
//   i_rgs_accum_reg(_vld) regression register and update pulse
//   o_busy                state != IDLE
//   o_done                one-cycle result-valid pulse
//   o_result              captured result, held until the next capture
module accum_feeder #(
  parameter int unsigned N_DTPS       = 4,
  parameter int unsigned FIFO_WIDTH   = 16,
  parameter int unsigned N_LABELS     = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic                           i_is_clf,
  input  logic [CNT_W-1:0]               i_n_results,
  input  logic                           i_abort,
  input  logic [N_DTPS-1:0]              i_dtp_vld,
  input  logic [N_DTPS*FIFO_WIDTH-1:0]   i_dtp_data,
  output logic [N_DTPS-1:0]              o_dtp_rdy,
  output logic [N_DTPS-1:0]              o_in_fifo_push,
  output logic [N_DTPS*FIFO_WIDTH-1:0]   o_in_fifo_rear,
  input  logic [N_DTPS-1:0]              i_in_fifo_is_full,
  output logic                           o_is_clf,
  output logic                           o_is_accum_fin,
  output logic                           o_flush,
  input  logic [N_LABELS*FIFO_WIDTH-1:0] i_clf_accum_reg,
  input  logic [N_LABELS-1:0]            i_clf_accum_reg_vld,
  input  logic [FIFO_WIDTH-1:0]          i_rgs_accum_reg,
  input  logic                           i_rgs_accum_reg_vld,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [FIFO_WIDTH-1:0]          o_result
);

  localparam int unsigned LBL_W = (N_LABELS > 1) ? $clog2(N_LABELS) : 1;
  localparam int unsigned DRN_W = 8;
  localparam logic [DRN_W-1:0] DRAIN_LAST =
    (DRAIN_CYCLES == 0) ? '0 : DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_FIN,
    S_WAIT_RES
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               is_clf_q;
  logic [CNT_W-1:0]   n_res_q;
  logic [CNT_W-1:0]   cnt     [N_DTPS];
  logic [CNT_W-1:0]   cnt_inc [N_DTPS];
  logic [DRN_W-1:0]   drain_cnt;

  logic [N_DTPS-1:0]  lane_done;
  logic [N_DTPS-1:0]  lane_fin;
  logic [N_DTPS-1:0]  rdy;
  logic [N_DTPS-1:0]  push;

  logic               start_ok;
  logic               drain_inc;
  logic               capture;
  logic [FIFO_WIDTH-1:0] cap_val;

  logic [FIFO_WIDTH-1:0] best_val;
  logic [LBL_W-1:0]      best_idx;

  logic               fin_q;
  logic               flush_q;
  logic               busy_q;
  logic               done_q;
  logic [FIFO_WIDTH-1:0] result_q;

  assign start_ok = (state == S_IDLE) & i_start & ~i_abort;

  // Per-lane handshake; lane_fin also folds in this cycle's handshake so the
  // FSM can leave FEED on the same edge as the last push.
  always_comb begin
    lane_done = '0;
    lane_fin  = '0;
    rdy       = '0;
    push      = '0;
    for (int unsigned l = 0; l < N_DTPS; l++) begin
      cnt_inc[l]   = cnt[l] + CNT_W'(1);
      lane_done[l] = (cnt[l] == n_res_q);
      rdy[l]       = (state == S_FEED) & ~lane_done[l] & ~i_in_fifo_is_full[l] & ~i_abort;
      push[l]      = i_dtp_vld[l] & rdy[l];
      lane_fin[l]  = lane_done[l] | (push[l] & (cnt_inc[l] == n_res_q));
    end
  end

  assign o_dtp_rdy      = rdy;
  assign o_in_fifo_push = push;
  assign o_in_fifo_rear = i_dtp_data;

  // Unsigned argmax; strict compare keeps the lowest index on ties.
  always_comb begin
    best_val = i_clf_accum_reg[0 +: FIFO_WIDTH];
    best_idx = '0;
    for (int unsigned l = 1; l < N_LABELS; l++) begin
      if (i_clf_accum_reg[l*FIFO_WIDTH +: FIFO_WIDTH] > best_val) begin
        best_val = i_clf_accum_reg[l*FIFO_WIDTH +: FIFO_WIDTH];
        best_idx = LBL_W'(l);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and capture decode; abort overrides everything.
  always_comb begin
    state_nxt = state;
    drain_inc = 1'b0;
    capture   = 1'b0;
    cap_val   = '0;
    if (i_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state_nxt = S_FEED;
          end
        end
        S_FEED: begin
          if (&lane_fin) begin
            state_nxt = (DRAIN_CYCLES == 0) ? S_FIN : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state_nxt = S_FIN;
          end else begin
            drain_inc = 1'b1;
          end
        end
        S_FIN: begin
          state_nxt = S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (is_clf_q && (|i_clf_accum_reg_vld)) begin
            capture   = 1'b1;
            cap_val   = FIFO_WIDTH'(best_idx);
            state_nxt = S_IDLE;
          end else if (!is_clf_q && i_rgs_accum_reg_vld) begin
            capture   = 1'b1;
            cap_val   = i_rgs_accum_reg;
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Job parameters latched at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_clf_q <= 1'b0;
      n_res_q  <= '0;
    end else if (start_ok) begin
      is_clf_q <= i_is_clf;
      n_res_q  <= i_n_results;
    end
  end

  // Per-lane result counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned l = 0; l < N_DTPS; l++) begin
        cnt[l] <= '0;
      end
    end else if (i_abort || start_ok) begin
      for (int unsigned l = 0; l < N_DTPS; l++) begin
        cnt[l] <= '0;
      end
    end else begin
      for (int unsigned l = 0; l < N_DTPS; l++) begin
        if (push[l]) begin
          cnt[l] <= cnt_inc[l];
        end
      end
    end
  end

  // Drain timer, cleared at every job start or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (i_abort || start_ok) begin
      drain_cnt <= '0;
    end else if (drain_inc) begin
      drain_cnt <= drain_cnt + DRN_W'(1);
    end
  end

  // Registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_q    <= 1'b0;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      fin_q   <= (state_nxt == S_FIN);
      flush_q <= i_abort;
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= capture;
      if (capture) begin
        result_q <= cap_val;
      end
    end
  end

  assign o_is_clf       = is_clf_q;
  assign o_is_accum_fin = fin_q;
  assign o_flush        = flush_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_result       = result_q;

endmodule

// File: tb/tb_accum_feeder.sv
// Directed bench for accum_feeder: feed phases with a per-lane push model,
// drain/finish timing, result capture through a scoreboard queue, abort and
// asynchronous reset.
module tb_accum_feeder;

  localparam int unsigned ND = 4;
  localparam int unsigned FW = 16;
  localparam int unsigned NL = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned DC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic              i_is_clf;
  logic [CW-1:0]     i_n_results;
  logic              i_abort;
  logic [ND-1:0]     i_dtp_vld;
  logic [ND*FW-1:0]  i_dtp_data;
  logic [ND-1:0]     o_dtp_rdy;
  logic [ND-1:0]     o_in_fifo_push;
  logic [ND*FW-1:0]  o_in_fifo_rear;
  logic [ND-1:0]     i_in_fifo_is_full;
  logic              o_is_clf;
  logic              o_is_accum_fin;
  logic              o_flush;
  logic [NL*FW-1:0]  i_clf_accum_reg;
  logic [NL-1:0]     i_clf_accum_reg_vld;
  logic [FW-1:0]     i_rgs_accum_reg;
  logic              i_rgs_accum_reg_vld;
  logic              o_busy;
  logic              o_done;
  logic [FW-1:0]     o_result;

  int compared   = 0;
  int mismatched = 0;
  logic [FW-1:0] exp_q[$];

  always #5 clk = ~clk;

  accum_feeder #(
    .N_DTPS(ND), .FIFO_WIDTH(FW), .N_LABELS(NL), .CNT_W(CW), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_is_clf(i_is_clf),
    .i_n_results(i_n_results), .i_abort(i_abort), .i_dtp_vld(i_dtp_vld),
    .i_dtp_data(i_dtp_data), .o_dtp_rdy(o_dtp_rdy), .o_in_fifo_push(o_in_fifo_push),
    .o_in_fifo_rear(o_in_fifo_rear), .i_in_fifo_is_full(i_in_fifo_is_full),
    .o_is_clf(o_is_clf), .o_is_accum_fin(o_is_accum_fin), .o_flush(o_flush),
    .i_clf_accum_reg(i_clf_accum_reg), .i_clf_accum_reg_vld(i_clf_accum_reg_vld),
    .i_rgs_accum_reg(i_rgs_accum_reg), .i_rgs_accum_reg_vld(i_rgs_accum_reg_vld),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Start a job (cycle 0) and run cycles 1..last with all lanes valid.
  // The model expects a push wherever the lane is short of n and not full.
  task automatic run_feed(input int n, input logic clf, input int full_lane,
                          input int full_from, input int full_to,
                          input int exp_fin, input int last, input bit poke);
    int ecnt[ND];
    int pcnt[ND];
    logic [ND-1:0] emask;
    for (int i = 0; i < int'(ND); i++) begin
      ecnt[i] = 0;
      pcnt[i] = 0;
    end
    tick();
    i_start           = 1'b1;
    i_is_clf          = clf;
    i_n_results       = CW'(n);
    i_dtp_vld         = '1;
    i_dtp_data        = {$urandom, $urandom};
    i_in_fifo_is_full = '0;
    #1;
    chk("c0_busy", 64'(o_busy), 64'(0));
    chk("c0_rdy", 64'(o_dtp_rdy), 64'(0));
    chk("c0_done", 64'(o_done), 64'(0));
    for (int c = 1; c <= last; c++) begin
      tick();
      i_start             = 1'b0;
      i_n_results         = CW'(n);
      i_clf_accum_reg_vld = '0;
      i_rgs_accum_reg_vld = 1'b0;
      i_dtp_data          = {$urandom, $urandom};
      for (int i = 0; i < int'(ND); i++) begin
        i_in_fifo_is_full[i] = (i == full_lane) && (c >= full_from) && (c <= full_to);
      end
      if (poke && c == 2) begin
        i_start             = 1'b1;
        i_n_results         = CW'(n + 3);
        i_clf_accum_reg_vld = '1;
        i_rgs_accum_reg_vld = 1'b1;
      end
      for (int i = 0; i < int'(ND); i++) begin
        emask[i] = (ecnt[i] < n) && !i_in_fifo_is_full[i];
      end
      #1;
      chk("rdy", 64'(o_dtp_rdy), 64'(emask));
      chk("push", 64'(o_in_fifo_push), 64'(emask));
      chk("rear", 64'(o_in_fifo_rear), 64'(i_dtp_data));
      chk("fin", 64'(o_is_accum_fin), 64'(c == exp_fin));
      chk("busy", 64'(o_busy), 64'(1));
      chk("is_clf", 64'(o_is_clf), 64'(clf));
      chk("feed_done", 64'(o_done), 64'(0));
      chk("feed_flush", 64'(o_flush), 64'(0));
      for (int i = 0; i < int'(ND); i++) begin
        if (o_in_fifo_push[i]) pcnt[i]++;
        if (emask[i]) ecnt[i]++;
      end
    end
    i_start             = 1'b0;
    i_clf_accum_reg_vld = '0;
    i_rgs_accum_reg_vld = 1'b0;
    if (exp_fin > 0) begin
      for (int i = 0; i < int'(ND); i++) begin
        chk("lane_total", 64'(pcnt[i]), 64'(n));
      end
    end
  endtask

  // One result-valid cycle in WAIT_RES, then check the following cycle.
  task automatic res_step(input logic [NL*FW-1:0] creg, input logic [NL-1:0] cvld,
                          input logic [FW-1:0] rreg, input logic rvld,
                          input bit cap, input logic [FW-1:0] expv);
    tick();
    i_clf_accum_reg     = creg;
    i_clf_accum_reg_vld = cvld;
    i_rgs_accum_reg     = rreg;
    i_rgs_accum_reg_vld = rvld;
    if (cap) exp_q.push_back(expv);
    #1;
    chk("res_busy_pre", 64'(o_busy), 64'(1));
    chk("res_done_pre", 64'(o_done), 64'(0));
    tick();
    i_clf_accum_reg_vld = '0;
    i_rgs_accum_reg_vld = 1'b0;
    #1;
    chk("res_done", 64'(o_done), 64'(cap));
    chk("res_busy", 64'(o_busy), 64'(!cap));
    if (o_done) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL result_unexpected: observed %0h expected none", o_result);
      end else begin
        chk("result", 64'(o_result), 64'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    rst                 = 1'b1;
    i_start             = 1'b0;
    i_is_clf            = 1'b0;
    i_n_results         = '0;
    i_abort             = 1'b0;
    i_dtp_vld           = '0;
    i_dtp_data          = '0;
    i_in_fifo_is_full   = '0;
    i_clf_accum_reg     = '0;
    i_clf_accum_reg_vld = '0;
    i_rgs_accum_reg     = '0;
    i_rgs_accum_reg_vld = 1'b0;
    #12;
    chk("rst_rdy", 64'(o_dtp_rdy), 64'(0));
    chk("rst_push", 64'(o_in_fifo_push), 64'(0));
    chk("rst_status", 64'({o_is_clf, o_is_accum_fin, o_flush, o_busy, o_done}), 64'(0));
    chk("rst_result", 64'(o_result), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Clf job, n=3, no back-pressure: finish at cycle 8, ties go low.
    run_feed(3, 1'b1, -1, 0, 0, 8, 8, 1'b0);
    res_step({16'd2, 16'd9, 16'd9, 16'd5}, 4'b0100, '0, 1'b0, 1'b1, 16'd1);

    // Lane 2 full in cycles 1-5: finish moves to cycle 13; rgs valid ignored.
    run_feed(3, 1'b1, 2, 1, 5, 13, 13, 1'b0);
    res_step('0, '0, 16'hBEEF, 1'b1, 1'b0, '0);
    res_step({16'd8, 16'd8, 16'd2, 16'd4}, 4'b1000, '0, 1'b0, 1'b1, 16'd2);

    // Rgs job, n=0: finish at cycle 6; clf valid ignored.
    run_feed(0, 1'b0, -1, 0, 0, 6, 6, 1'b0);
    res_step({16'd1, 16'd2, 16'd3, 16'd4}, 4'b1111, '0, 1'b0, 1'b0, '0);
    res_step('0, '0, 16'h1234, 1'b1, 1'b1, 16'h1234);

    // Abort during DRAIN: flush pulse, back to IDLE, no finish or done.
    run_feed(1, 1'b1, -1, 0, 0, -1, 2, 1'b0);
    tick();
    i_abort = 1'b1;
    #1;
    chk("abort_rdy", 64'(o_dtp_rdy), 64'(0));
    tick();
    i_abort = 1'b0;
    #1;
    chk("flush_on", 64'(o_flush), 64'(1));
    chk("abort_busy", 64'(o_busy), 64'(0));
    tick();
    #1;
    chk("flush_off", 64'(o_flush), 64'(0));
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      chk("abort_fin", 64'(o_is_accum_fin), 64'(0));
      chk("abort_done", 64'(o_done), 64'(0));
    end
    chk("result_held", 64'(o_result), 64'(16'h1234));

    // Restart after abort, with a stray start and result valids mid-FEED.
    run_feed(2, 1'b1, -1, 0, 0, 7, 7, 1'b1);
    chk("poke_result", 64'(o_result), 64'(16'h1234));
    res_step({16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000}, 4'b0001, '0, 1'b0, 1'b1, 16'd3);

    // Reset asserted mid-FEED with pushes active.
    run_feed(5, 1'b1, -1, 0, 0, -1, 2, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 64'(o_dtp_rdy), 64'(0));
    chk("mid_rst_push", 64'(o_in_fifo_push), 64'(0));
    chk("mid_rst_status", 64'({o_is_clf, o_is_accum_fin, o_flush, o_busy, o_done}), 64'(0));
    chk("mid_rst_result", 64'(o_result), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(o_dtp_rdy), 64'(0));
    tick();
    #1;
    chk("post_rst_busy", 64'(o_busy), 64'(0));
    chk("post_rst_push", 64'(o_in_fifo_push), 64'(0));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
